// File: rtl/data_memory_ctrl.sv
// Multi-cycle RV32I data memory: valid/ready requests, configurable wait states, B/H/W loads and stores.
// Optional power-on array clear is compiled in with the MEM_CLEAR_EN macro.
module data_memory_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [2:0]            Funct3,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           WriteData,
    output logic                  RespValid,
    output logic [31:0]           ReadData,
    output logic                  Fault,
    output logic                  Busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_RESP  = 2'd2
`ifdef MEM_CLEAR_EN
        , S_CLEAR = 2'd3
`endif
    } state_t;

`ifdef MEM_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
    localparam logic   RESET_BUSY  = 1'b1;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    function automatic logic check_fault(input logic wr, input logic [2:0] f3,
                                         input logic [1:0] lo, input logic out_of_range);
        logic bad;
        bad = out_of_range;
        case (f3)
            3'b000:  bad = bad;
            3'b001:  bad = bad | lo[0];
            3'b010:  bad = bad | (lo != 2'b00);
            3'b100:  bad = bad | wr;
            3'b101:  bad = bad | wr | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] m;
        case (f3)
            3'b000: begin
                case (lo)
                    2'b00:   m = 32'h0000_00FF;
                    2'b01:   m = 32'h0000_FF00;
                    2'b10:   m = 32'h00FF_0000;
                    default: m = 32'hFF00_0000;
                endcase
            end
            3'b001:  m = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            3'b010:  m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lo)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    logic [31:0]           mem_r [DEPTH_WORDS];
    state_t                state_r;
    state_t                next_s;
    logic                  ready_r;
    logic                  busy_r;
    logic                  resp_valid_r;
    logic [31:0]           rdata_r;
    logic                  fault_r;
    logic                  write_r;
    logic [2:0]            funct3_r;
    logic [IDX_W+1:0]      addr_r;
    logic [31:0]           wdata_r;
    logic [3:0]            cnt_r;
`ifdef MEM_CLEAR_EN
    logic [IDX_W-1:0]      clear_idx_r;
`endif

    logic                  accept_s;
    logic                  in_oor_s;
    logic                  in_fault_s;
    logic                  acc_write_s;
    logic [2:0]            acc_f3_s;
    logic [IDX_W+1:0]      acc_addr_s;
    logic [31:0]           acc_wdata_s;
    logic                  acc_fault_s;
    logic [IDX_W-1:0]      acc_idx_s;
    logic [31:0]           rd_word_s;
    logic                  do_access_s;

    assign accept_s   = ReqValid & ready_r;
    assign in_oor_s   = Address[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH_WORDS);
    assign in_fault_s = check_fault(ReqWrite, Funct3, Address[1:0], in_oor_s);

    // With zero wait states the access happens on the accepting edge, so it must see the live inputs.
    always_comb begin
        acc_write_s = write_r;
        acc_f3_s    = funct3_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        acc_fault_s = 1'b0;
        if (state_r == S_IDLE) begin
            acc_write_s = ReqWrite;
            acc_f3_s    = Funct3;
            acc_addr_s  = Address[IDX_W+1:0];
            acc_wdata_s = WriteData;
            acc_fault_s = in_fault_s;
        end else begin
            acc_fault_s = 1'b0;
        end
    end

    assign acc_idx_s   = acc_addr_s[IDX_W+1:2];
    assign rd_word_s   = mem_r[acc_idx_s];
    assign do_access_s = (next_s == S_RESP) & ~acc_fault_s & ~Reset;

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (in_fault_s || (WAIT_STATES == 0)) begin
                        next_s = S_RESP;
                    end else begin
                        next_s = S_WAIT;
                    end
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    next_s = S_RESP;
                end else begin
                    next_s = S_WAIT;
                end
            end
            S_RESP: next_s = S_IDLE;
`ifdef MEM_CLEAR_EN
            S_CLEAR: begin
                if (clear_idx_r == IDX_W'(DEPTH_WORDS - 1)) begin
                    next_s = S_IDLE;
                end else begin
                    next_s = S_CLEAR;
                end
            end
`endif
            default: next_s = S_IDLE;
        endcase
    end

    // State, request capture, wait counter and registered response outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r      <= RESET_STATE;
            ready_r      <= 1'b0;
            busy_r       <= RESET_BUSY;
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'd0;
            fault_r      <= 1'b0;
            write_r      <= 1'b0;
            funct3_r     <= 3'd0;
            addr_r       <= '0;
            wdata_r      <= 32'd0;
            cnt_r        <= 4'd0;
        end else begin
            state_r      <= next_s;
            ready_r      <= (next_s == S_IDLE);
            busy_r       <= (next_s != S_IDLE);
            resp_valid_r <= (next_s == S_RESP);
            if (accept_s) begin
                write_r  <= ReqWrite;
                funct3_r <= Funct3;
                addr_r   <= Address[IDX_W+1:0];
                wdata_r  <= WriteData;
                cnt_r    <= 4'(WAIT_STATES);
            end else if (state_r == S_WAIT) begin
                cnt_r    <= cnt_r - 4'd1;
            end else begin
                cnt_r    <= cnt_r;
            end
            if (next_s == S_RESP) begin
                fault_r <= acc_fault_s;
                rdata_r <= (acc_fault_s || acc_write_s) ? 32'd0
                                                        : load_ext(acc_f3_s, acc_addr_s[1:0], rd_word_s);
            end else begin
                fault_r <= 1'b0;
            end
        end
    end

`ifdef MEM_CLEAR_EN
    // Sweep index; any reset restarts the sweep from word 0.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            clear_idx_r <= '0;
        end else if (state_r == S_CLEAR) begin
            clear_idx_r <= clear_idx_r + IDX_W'(1);
        end else begin
            clear_idx_r <= clear_idx_r;
        end
    end
`endif

    // Data array: not reset, so contents survive reset unless the sweep clears them.
    always_ff @(posedge CLK) begin
`ifdef MEM_CLEAR_EN
        if (!Reset && (state_r == S_CLEAR)) begin
            mem_r[clear_idx_r] <= 32'd0;
        end else
`endif
        if (do_access_s && acc_write_s) begin
            mem_r[acc_idx_s] <= (rd_word_s & ~store_mask(acc_f3_s, acc_addr_s[1:0]))
                              | (store_data(acc_f3_s, acc_wdata_s) & store_mask(acc_f3_s, acc_addr_s[1:0]));
        end
    end

    assign ReqReady  = ready_r;
    assign Busy      = busy_r;
    assign RespValid = resp_valid_r;
    assign ReadData  = rdata_r;
    assign Fault     = fault_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (DEPTH_WORDS=256, WAIT_STATES=2).
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        fault;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] got_data;
    logic        got_fault;
    int          got_lat;
    logic        got_ready_wait;
    logic        got_ready_after;
    logic        got_resp_after;
    logic [31:0] got_data_after;

    data_memory_ctrl #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_WIDTH(32)) dut (
        .CLK(clk), .Reset(reset), .ReqValid(req_valid), .ReqReady(req_ready),
        .ReqWrite(req_write), .Funct3(funct3), .Address(address), .WriteData(write_data),
        .RespValid(resp_valid), .ReadData(read_data), .Fault(fault), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        int  w;
        logic done;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_write = wr; funct3 = f3; address = addr; write_data = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0; address = 32'd0; write_data = 32'd0;
        got_lat = 0; done = 1'b0; got_ready_wait = 1'b0;
        got_data = 32'hXXXX_XXXX; got_fault = 1'bx;
        while (!done && got_lat < 20) begin
            @(negedge clk);
            got_lat++;
            if (req_ready) got_ready_wait = 1'b1;
            if (resp_valid) begin
                done = 1'b1;
                got_data = read_data;
                got_fault = fault;
            end
        end
        if (!done) check("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        got_ready_after = req_ready;
        got_resp_after  = resp_valid;
        got_data_after  = read_data;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic any_resp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
`ifdef MEM_CLEAR_EN
        check("rst_busy", {31'd0, busy}, 32'd1);
`else
        check("rst_busy", {31'd0, busy}, 32'd0);
`endif
        reset = 1'b0;
        n = 0;
        while (busy && !req_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
`ifdef MEM_CLEAR_EN
        check("clear_len", n, 32'd256);
        do_req(1'b0, 3'b010, 32'h04, 32'd0);
        check("lw_cleared", got_data, 32'd0);
        check("lw_cleared_flt", {31'd0, got_fault}, 32'd0);
`else
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_rst", n, 32'd1);
`endif

        // Store then load with handshake timing checks.
        do_req(1'b1, 3'b010, 32'h04, 32'hCAFE_BABE);
        check("sw_lat", got_lat, 32'd3);
        check("sw_fault", {31'd0, got_fault}, 32'd0);
        check("sw_rdata", got_data, 32'd0);
        check("sw_ready_wait", {31'd0, got_ready_wait}, 32'd0);
        check("sw_ready_after", {31'd0, got_ready_after}, 32'd1);
        check("sw_one_strobe", {31'd0, got_resp_after}, 32'd0);
        do_req(1'b0, 3'b010, 32'h04, 32'd0);
        check("lw_lat", got_lat, 32'd3);
        check("lw_data", got_data, 32'hCAFE_BABE);
        check("lw_hold", got_data_after, 32'hCAFE_BABE);

        // Retention across reset (or clearing when the sweep is built in).
        do_req(1'b1, 3'b010, 32'h08, 32'hA5A5_A5A5);
        pulse_reset();
        do_req(1'b0, 3'b010, 32'h04, 32'd0);
`ifdef MEM_CLEAR_EN
        check("lw_after_rst", got_data, 32'd0);
        do_req(1'b1, 3'b010, 32'h04, 32'hCAFE_BABE);
`else
        check("lw_after_rst", got_data, 32'hCAFE_BABE);
`endif

        // Sub-word loads.
        do_req(1'b0, 3'b000, 32'h04, 32'd0);
        check("lb_04", got_data, 32'hFFFF_FFBE);
        do_req(1'b0, 3'b100, 32'h07, 32'd0);
        check("lbu_07", got_data, 32'h0000_00CA);
        do_req(1'b0, 3'b001, 32'h06, 32'd0);
        check("lh_06", got_data, 32'hFFFF_CAFE);
        do_req(1'b0, 3'b101, 32'h04, 32'd0);
        check("lhu_04", got_data, 32'h0000_BABE);

        // Partial stores.
        do_req(1'b1, 3'b000, 32'h05, 32'hFFFF_FF11);
        do_req(1'b0, 3'b010, 32'h04, 32'd0);
        check("sb_merge", got_data, 32'hCAFE_11BE);
        do_req(1'b1, 3'b001, 32'h06, 32'h1234_BEEF);
        do_req(1'b0, 3'b010, 32'h04, 32'd0);
        check("sh_merge", got_data, 32'hBEEF_11BE);

        // Fault cases: immediate response, no memory access.
        do_req(1'b0, 3'b010, 32'h06, 32'd0);
        check("lw_mis_flt", {31'd0, got_fault}, 32'd1);
        check("lw_mis_data", got_data, 32'd0);
        check("flt_lat", got_lat, 32'd1);
        do_req(1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF);
        check("sw_oor_flt", {31'd0, got_fault}, 32'd1);
        do_req(1'b1, 3'b010, 32'h404, 32'hDEAD_BEEF);
        check("sw_oor2_flt", {31'd0, got_fault}, 32'd1);
        do_req(1'b0, 3'b011, 32'h04, 32'd0);
        check("ld_011_flt", {31'd0, got_fault}, 32'd1);
        do_req(1'b1, 3'b001, 32'h05, 32'hFFFF_FFFF);
        check("sh_mis_flt", {31'd0, got_fault}, 32'd1);
        do_req(1'b1, 3'b100, 32'h04, 32'hFFFF_FFFF);
        check("st_100_flt", {31'd0, got_fault}, 32'd1);
        do_req(1'b0, 3'b010, 32'h04, 32'd0);
        check("unchanged", got_data, 32'hBEEF_11BE);
        check("unchanged_flt", {31'd0, got_fault}, 32'd0);

        // Reset during WAIT aborts the store.
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; address = 32'h08; write_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        any_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) any_resp = 1'b1;
            @(negedge clk);
        end
        check("abort_no_resp", {31'd0, any_resp}, 32'd0);
        do_req(1'b0, 3'b010, 32'h08, 32'd0);
`ifdef MEM_CLEAR_EN
        check("abort_data", got_data, 32'd0);
`else
        check("abort_data", got_data, 32'hA5A5_A5A5);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
